// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush controller.
// Handles the hazards that forwarding cannot resolve:
//   - load-use into EXE
//   - branch operands in ID that are not yet forwardable
//   - multi-cycle mul/div occupying EXE (tracked by a small FSM with a watchdog)
//   - data-memory wait states
//   - taken-branch redirect
// Optional: define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
// Without it, perf_stall_cnt and perf_flush_cnt are tied to zero.

`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module hazard_unit #(
   parameter int MULDIV_MAX_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`GPR_ADDR_SPACE] id_rs1_addr,
   input  logic                   id_rs1_re,
   input  logic [`GPR_ADDR_SPACE] id_rs2_addr,
   input  logic                   id_rs2_re,
   input  logic                   id_is_branch,
   input  logic [`GPR_ADDR_SPACE] id_exe_rd_addr,
   input  logic                   id_exe_rd_we,
   input  logic                   id_exe_mem_re,
   input  logic [`GPR_ADDR_SPACE] exe_mem_rd_addr,
   input  logic                   exe_mem_rd_we,
   input  logic                   exe_mem_mem_re,
   input  logic                   exe_muldiv_start,
   input  logic                   exe_muldiv_done,
   input  logic                   mem_busy,
   input  logic                   branch_taken,
   output logic                   pc_stall,
   output logic                   if_id_stall,
   output logic                   if_id_flush,
   output logic                   id_exe_stall,
   output logic                   id_exe_flush,
   output logic                   exe_mem_stall,
   output logic                   exe_mem_flush,
   output logic [1:0]             hazard_state,
   output logic                   hazard_err,
   output logic [31:0]            perf_stall_cnt,
   output logic [31:0]            perf_flush_cnt
);

   localparam int WD_W = $clog2(MULDIV_MAX_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MULDIV_MAX_CYCLES - 1);

   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] MULDIV_BUSY = 2'd1;

   logic [1:0]      state;
   logic [WD_W-1:0] wd_cnt;
   logic            load_use;
   logic            br_haz;
   logic            md_busy;

   // A producer hazards a consumer only for a real register (never x0) that is both read and written.
   function automatic logic match(input logic [`GPR_ADDR_SPACE] a, input logic re,
                                  input logic [`GPR_ADDR_SPACE] rd, input logic we);
      return (a != '0) && (a == rd) && re && we;
   endfunction

   // Hazard detection. A non-load in MEM is forwarded to the branch unit, so only a load there stalls a branch.
   always_comb begin
      load_use = id_exe_mem_re &&
                 (match(id_rs1_addr, id_rs1_re, id_exe_rd_addr, id_exe_rd_we) ||
                  match(id_rs2_addr, id_rs2_re, id_exe_rd_addr, id_exe_rd_we));
      br_haz   = id_is_branch &&
                 (match(id_rs1_addr, id_rs1_re, id_exe_rd_addr, id_exe_rd_we) ||
                  match(id_rs2_addr, id_rs2_re, id_exe_rd_addr, id_exe_rd_we) ||
                  (exe_mem_mem_re &&
                   (match(id_rs1_addr, id_rs1_re, exe_mem_rd_addr, exe_mem_rd_we) ||
                    match(id_rs2_addr, id_rs2_re, exe_mem_rd_addr, exe_mem_rd_we))));
      md_busy  = ((state == IDLE) && exe_muldiv_start && !exe_muldiv_done) ||
                 ((state == MULDIV_BUSY) && !exe_muldiv_done);
   end

   // Prioritised stall/flush controls. All controls are held off while in reset.
   always_comb begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_exe_stall  = 1'b0;
      id_exe_flush  = 1'b0;
      exe_mem_stall = 1'b0;
      exe_mem_flush = 1'b0;
      if (!rst) begin
         if (mem_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_stall  = 1'b1;
            exe_mem_stall = 1'b1;
         end else if (md_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_stall  = 1'b1;
            exe_mem_flush = 1'b1;
         end else if (load_use || br_haz) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_flush  = 1'b1;
         end else if (branch_taken) begin
            if_id_flush   = 1'b1;
         end
      end
   end

   // Mul/div occupancy FSM with watchdog. It advances even while memory is busy.
   // On timeout it raises a sticky error and returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wd_cnt     <= '0;
         hazard_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (exe_muldiv_start && !exe_muldiv_done) begin
                  state  <= MULDIV_BUSY;
                  wd_cnt <= '0;
               end
            end
            MULDIV_BUSY: begin
               if (exe_muldiv_done) begin
                  state <= IDLE;
               end else if (wd_cnt == WD_LIMIT) begin
                  hazard_err <= 1'b1;
                  state      <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign hazard_state = state;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   // Free-running, wrapping counts of stalled-PC cycles and redirect flushes.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall) stall_cnt <= stall_cnt + 32'd1;
         if (if_id_flush) flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt;
   assign perf_flush_cnt = flush_cnt;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven and sequence checks of hazard_unit through an expected-result queue.

`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module tb_hazard_unit;

   // Control vector order: pc_s, if_id_s, if_id_f, id_exe_s, id_exe_f, exe_mem_s, exe_mem_f
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] MEMB = 7'b1101010;
   localparam logic [6:0] MD   = 7'b1101001;
   localparam logic [6:0] LU   = 7'b1100100;
   localparam logic [6:0] BR   = 7'b0010000;

   typedef struct packed {
      logic [`GPR_ADDR_SPACE] rs1;
      logic                   re1;
      logic [`GPR_ADDR_SPACE] rs2;
      logic                   re2;
      logic                   br;
      logic [`GPR_ADDR_SPACE] exeRd;
      logic                   exeWe;
      logic                   exeMre;
      logic [`GPR_ADDR_SPACE] memRd;
      logic                   memWe;
      logic                   memMre;
      logic                   start;
      logic                   done;
      logic                   busy;
      logic                   taken;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [6:0] ctrl;
      logic [1:0] st;
      logic       err;
      string      name;
   } vec_t;

   typedef struct {
      logic [6:0] ctrl;
      logic [1:0] st;
      logic       err;
      string      name;
   } exp_t;

   exp_t sbQueue[$];
   int   checks = 0;
   int   errors = 0;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [`GPR_ADDR_SPACE] id_rs1_addr = '0;
   logic                   id_rs1_re = 1'b0;
   logic [`GPR_ADDR_SPACE] id_rs2_addr = '0;
   logic                   id_rs2_re = 1'b0;
   logic                   id_is_branch = 1'b0;
   logic [`GPR_ADDR_SPACE] id_exe_rd_addr = '0;
   logic                   id_exe_rd_we = 1'b0;
   logic                   id_exe_mem_re = 1'b0;
   logic [`GPR_ADDR_SPACE] exe_mem_rd_addr = '0;
   logic                   exe_mem_rd_we = 1'b0;
   logic                   exe_mem_mem_re = 1'b0;
   logic                   exe_muldiv_start = 1'b0;
   logic                   exe_muldiv_done = 1'b0;
   logic                   mem_busy = 1'b0;
   logic                   branch_taken = 1'b0;
   logic                   pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
   logic                   exe_mem_stall, exe_mem_flush, hazard_err;
   logic [1:0]             hazard_state;
   logic [31:0]            perf_stall_cnt, perf_flush_cnt;
   logic [6:0]             ctrlVec;

   always #5 clk = ~clk;

   hazard_unit #(.MULDIV_MAX_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs1_re(id_rs1_re),
      .id_rs2_addr(id_rs2_addr), .id_rs2_re(id_rs2_re),
      .id_is_branch(id_is_branch),
      .id_exe_rd_addr(id_exe_rd_addr), .id_exe_rd_we(id_exe_rd_we), .id_exe_mem_re(id_exe_mem_re),
      .exe_mem_rd_addr(exe_mem_rd_addr), .exe_mem_rd_we(exe_mem_rd_we), .exe_mem_mem_re(exe_mem_mem_re),
      .exe_muldiv_start(exe_muldiv_start), .exe_muldiv_done(exe_muldiv_done),
      .mem_busy(mem_busy), .branch_taken(branch_taken),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_exe_stall(id_exe_stall), .id_exe_flush(id_exe_flush),
      .exe_mem_stall(exe_mem_stall), .exe_mem_flush(exe_mem_flush),
      .hazard_state(hazard_state), .hazard_err(hazard_err),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   assign ctrlVec = {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush, exe_mem_stall, exe_mem_flush};

   function automatic stim_t mkStim(
      input logic [`GPR_ADDR_SPACE] rs1, input logic re1,
      input logic [`GPR_ADDR_SPACE] rs2, input logic re2, input logic br,
      input logic [`GPR_ADDR_SPACE] exeRd, input logic exeWe, input logic exeMre,
      input logic [`GPR_ADDR_SPACE] memRd, input logic memWe, input logic memMre,
      input logic start, input logic done, input logic busy, input logic taken);
      stim_t s;
      s.rs1 = rs1; s.re1 = re1; s.rs2 = rs2; s.re2 = re2; s.br = br;
      s.exeRd = exeRd; s.exeWe = exeWe; s.exeMre = exeMre;
      s.memRd = memRd; s.memWe = memWe; s.memMre = memMre;
      s.start = start; s.done = done; s.busy = busy; s.taken = taken;
      return s;
   endfunction

   function automatic vec_t mkVec(input stim_t s, input logic [6:0] c, input string nm);
      vec_t v;
      v.s = s; v.ctrl = c; v.st = 2'd0; v.err = 1'b0; v.name = nm;
      return v;
   endfunction

   // Drive one cycle of inputs and queue the outputs they must produce
   task automatic applyStimulus(input stim_t s, input logic [6:0] c, input logic [1:0] st,
                                input logic e, input string nm);
      exp_t x;
      id_rs1_addr      = s.rs1;
      id_rs1_re        = s.re1;
      id_rs2_addr      = s.rs2;
      id_rs2_re        = s.re2;
      id_is_branch     = s.br;
      id_exe_rd_addr   = s.exeRd;
      id_exe_rd_we     = s.exeWe;
      id_exe_mem_re    = s.exeMre;
      exe_mem_rd_addr  = s.memRd;
      exe_mem_rd_we    = s.memWe;
      exe_mem_mem_re   = s.memMre;
      exe_muldiv_start = s.start;
      exe_muldiv_done  = s.done;
      mem_busy         = s.busy;
      branch_taken     = s.taken;
      x.ctrl = c; x.st = st; x.err = e; x.name = nm;
      sbQueue.push_back(x);
   endtask

   // Pop the oldest expectation and compare it to the DUT at the falling edge
   task automatic checkOutput();
      exp_t       x;
      logic [9:0] act;
      logic [9:0] req;
      @(negedge clk);
      checks++;
      if (sbQueue.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty actual=none required=entry");
      end else begin
         x   = sbQueue.pop_front();
         act = {ctrlVec, hazard_state, hazard_err};
         req = {x.ctrl, x.st, x.err};
         if (act !== req)
         begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b (ctrl,state,err)", x.name, act, req);
         end
      end
   endtask

   task automatic step(input stim_t s, input logic [6:0] c, input logic [1:0] st,
                       input logic e, input string nm);
      applyStimulus(s, c, st, e, nm);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t  tbl[17];
      stim_t idleS, luS, takenS, startS, doneS, busyS;
      logic [31:0] expStall, expFlush;

      idleS  = mkStim(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
      luS    = mkStim(5,1,0,0,0, 5,1,1, 0,0,0, 0,0,0,0);
      takenS = mkStim(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1);
      startS = mkStim(0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0,0);
      doneS  = mkStim(0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0,0);
      busyS  = mkStim(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1,0);

      tbl[0]  = mkVec(luS, LU, "lu_rs1");
      tbl[1]  = mkVec(mkStim(0,1,0,0,0, 0,1,1, 0,0,0, 0,0,0,0), NONE, "lu_x0");
      tbl[2]  = mkVec(mkStim(0,0,9,1,0, 9,1,1, 0,0,0, 0,0,0,0), LU,   "lu_rs2");
      tbl[3]  = mkVec(mkStim(5,0,0,0,0, 5,1,1, 0,0,0, 0,0,0,0), NONE, "lu_no_re");
      tbl[4]  = mkVec(mkStim(5,1,0,0,0, 5,1,0, 0,0,0, 0,0,0,0), NONE, "alu_not_branch");
      tbl[5]  = mkVec(mkStim(0,0,7,1,1, 7,1,0, 0,0,0, 0,0,0,0), LU,   "br_exe_alu");
      tbl[6]  = mkVec(mkStim(0,0,7,1,1, 0,0,0, 7,1,1, 0,0,0,0), LU,   "br_mem_load");
      tbl[7]  = mkVec(mkStim(0,0,7,1,1, 0,0,0, 7,1,0, 0,0,0,0), NONE, "br_mem_alu");
      tbl[8]  = mkVec(takenS, BR, "taken_only");
      tbl[9]  = mkVec(mkStim(5,1,0,0,0, 5,1,1, 0,0,0, 0,0,1,1), MEMB, "prio_membusy");
      tbl[10] = mkVec(mkStim(5,1,0,0,0, 5,1,1, 0,0,0, 0,0,0,1), LU,   "prio_lu_over_taken");
      tbl[11] = mkVec(mkStim(0,0,0,0,0, 0,0,0, 0,0,0, 1,1,0,0), NONE, "md_start_done");
      tbl[12] = mkVec(mkStim(5,1,0,0,0, 5,0,1, 0,0,0, 0,0,0,0), NONE, "load_no_we");
      tbl[13] = mkVec(mkStim(0,0,7,1,1, 7,0,0, 0,0,0, 0,0,0,0), NONE, "br_exe_no_we");
      tbl[14] = mkVec(mkStim(0,1,0,0,1, 0,1,0, 0,1,1, 0,0,0,0), NONE, "br_x0");
      tbl[15] = mkVec(busyS, MEMB, "membusy_only");
      tbl[16] = mkVec(mkStim(7,1,0,0,1, 0,0,0, 7,0,1, 0,0,0,0), NONE, "br_mem_no_we");

      // Reset: controls forced off even with mem_busy, state/err cleared
      rst = 1'b1;
      @(posedge clk);
      #1;
      step(busyS, NONE, 2'd0, 1'b0, "reset_override");
      rst = 1'b0;

      // Combinational vectors from IDLE
      for (int i = 0; i < 17; i++) step(tbl[i].s, tbl[i].ctrl, tbl[i].st, tbl[i].err, tbl[i].name);

      // Load-use stalls exactly one cycle; the load then sits in MEM
      step(luS, LU, 2'd0, 1'b0, "lu_seq_c0");
      step(mkStim(5,1,0,0,0, 0,0,0, 5,1,1, 0,0,0,0), NONE, 2'd0, 1'b0, "lu_seq_c1");

      // Mul/div start at cycle 0 (with a load-use), done at cycle 4, mem_busy at cycle 2
      step(mkStim(5,1,0,0,0, 5,1,1, 0,0,0, 1,0,0,0), MD, 2'd0, 1'b0, "md_c0");
      step(idleS, MD,   2'd1, 1'b0, "md_c1");
      step(busyS, MEMB, 2'd1, 1'b0, "md_c2_membusy");
      step(idleS, MD,   2'd1, 1'b0, "md_c3");
      step(doneS, NONE, 2'd1, 1'b0, "md_c4_done");
      step(idleS, NONE, 2'd0, 1'b0, "md_c5_idle");

      // Watchdog with limit 8: start and never finish
      step(startS, MD, 2'd0, 1'b0, "wd_c0");
      for (int k = 1; k <= 8; k++) step(idleS, MD, 2'd1, 1'b0, "wd_busy");
      step(idleS, NONE, 2'd0, 1'b1, "wd_released");
      step(idleS, NONE, 2'd0, 1'b1, "wd_err_sticky");

      // Reset pulse overrides a load-use and clears the sticky error
      rst = 1'b1;
      step(luS, NONE, 2'd0, 1'b1, "rst_override_lu");
      rst = 1'b0;
      step(idleS, NONE, 2'd0, 1'b0, "wd_err_cleared");

      // Performance counters: 3 stall cycles and 2 redirect flushes since reset
      for (int k = 0; k < 3; k++) step(luS, LU, 2'd0, 1'b0, "perf_stall");
      for (int k = 0; k < 2; k++) step(takenS, BR, 2'd0, 1'b0, "perf_taken");
      applyStimulus(idleS, NONE, 2'd0, 1'b0, "perf_idle");
      checkOutput();
`ifdef HAZARD_PERF_CNT_EN
      expStall = 32'd3;
      expFlush = 32'd2;
`else
      expStall = 32'd0;
      expFlush = 32'd0;
`endif
      checks++;
      if (perf_stall_cnt !== expStall) begin
         errors++;
         $display("[TB] FAIL perf_stall_cnt actual=%0d required=%0d", perf_stall_cnt, expStall);
      end
      checks++;
      if (perf_flush_cnt !== expFlush) begin
         errors++;
         $display("[TB] FAIL perf_flush_cnt actual=%0d required=%0d", perf_flush_cnt, expFlush);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline stall/flush controller in the core.
- Sits beside the forwarding unit; covers every hazard forwarding cannot resolve:
  - load-use into EXE
  - branch operands in ID not yet forwardable
  - multi-cycle mul/div occupying EXE
  - data-memory wait states
  - taken-branch redirect
- Drives stall/flush controls of PC, IF_ID, ID_EXE and EXE_MEM registers; tracks mul/div occupancy with a small FSM and watchdog.

Parameters:
MULDIV_MAX_CYCLES, 64, watchdog limit for one mul/div op; counter width $clog2(MULDIV_MAX_CYCLES)+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1_addr  in  `GPR_ADDR_SPACE  ID rs1 index
id_rs1_re  in  1  ID reads rs1
id_rs2_addr  in  `GPR_ADDR_SPACE  ID rs2 index
id_rs2_re  in  1  ID reads rs2
id_is_branch  in  1  ID instr is branch/jalr resolved in ID
id_exe_rd_addr  in  `GPR_ADDR_SPACE  EXE-stage rd
id_exe_rd_we  in  1  EXE-stage writes rd
id_exe_mem_re  in  1  EXE-stage instr is load
exe_mem_rd_addr  in  `GPR_ADDR_SPACE  MEM-stage rd
exe_mem_rd_we  in  1  MEM-stage writes rd
exe_mem_mem_re  in  1  MEM-stage instr is load
exe_muldiv_start  in  1  mul/div op in EXE this cycle (first cycle)
exe_muldiv_done  in  1  mul/div result valid this cycle
mem_busy  in  1  data memory not ready
branch_taken  in  1  branch unit redirects PC
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF_ID
if_id_flush  out  1  bubble into IF_ID
id_exe_stall  out  1  hold ID_EXE
id_exe_flush  out  1  bubble into ID_EXE
exe_mem_stall  out  1  hold EXE_MEM
exe_mem_flush  out  1  bubble into EXE_MEM
hazard_state  out  2  FSM state: 0 IDLE, 1 MULDIV_BUSY
hazard_err  out  1  sticky watchdog error
perf_stall_cnt  out  32  stall-cycle counter (feature)
perf_flush_cnt  out  32  redirect-flush counter (feature)

Behaviour:
- Reset: rst high at posedge -> state IDLE, watchdog counter 0, hazard_err 0, perf counters 0. While rst high, all stall/flush outputs forced `Off.
- Stall/flush outputs combinational from inputs and current state (same-cycle effect). State, counters, hazard_err registered.
- Match(a, re, rd, we): a != 0 && a == rd && re && we. x0 never causes a hazard.
- load_use: id_exe_mem_re && Match(id_rsN, id_exe_rd) for N = 1 or 2.
- br_haz: id_is_branch && (Match(id_rsN, id_exe_rd) || (exe_mem_mem_re && Match(id_rsN, exe_mem_rd))). Non-load EXE_MEM sources are forwarded to the branch unit, so they do not stall. MEM_WB sources are covered by register-file write bypass.
- md_busy: (IDLE && exe_muldiv_start && !exe_muldiv_done) || (MULDIV_BUSY && !exe_muldiv_done).
- Output priority, highest first:
  1. mem_busy: pc, if_id, id_exe, exe_mem stall = 1; all flushes 0.
  2. md_busy: pc, if_id, id_exe stall = 1; exe_mem_flush = 1.
  3. load_use || br_haz: pc, if_id stall = 1; id_exe_flush = 1.
  4. branch_taken: if_id_flush = 1.
  5. Otherwise all 0.
- branch_taken is ignored whenever a higher-priority condition holds. The branch unit re-asserts it once operands are valid.
- FSM:
  - IDLE -> MULDIV_BUSY on exe_muldiv_start && !exe_muldiv_done.
  - Start with done in the same cycle -> stay IDLE, no stall.
  - MULDIV_BUSY -> IDLE on exe_muldiv_done; no stall in the done cycle.
- Watchdog:
  - Counter clears on IDLE->MULDIV_BUSY; increments each MULDIV_BUSY cycle, including cycles during mem_busy.
  - When it reaches MULDIV_MAX_CYCLES-1 without done: hazard_err <= 1 (sticky until rst), FSM -> IDLE, stall released next cycle.
- FSM transitions are evaluated regardless of mem_busy.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt += 1 each non-reset cycle with pc_stall = 1.
  - perf_flush_cnt += 1 each cycle with if_id_flush = 1.
  - Both wrap at 2^32.
- Undefined: counters not instantiated; both ports tied to 0.

Test Plan:
- Load-use: id_exe_rd=5, we=1, mem_re=1; id_rs1=5, re=1 -> pc_stall=if_id_stall=id_exe_flush=1 for exactly 1 cycle. Same with rd=0 -> all outputs 0.
- Branch operands: id_is_branch=1, id_rs2=7:
  - id_exe_rd=7 (ALU) -> 1-cycle stall + id_exe_flush.
  - exe_mem_rd=7, mem_re=1 -> stall.
  - exe_mem_rd=7, mem_re=0 -> no stall.
- Mul/div: start at cycle 0, done at cycle 4 -> pc/if_id/id_exe stall + exe_mem_flush cycles 0-3; hazard_state=1 cycles 1-4, 0 at cycle 5. Start and done together -> no stall.
- Priority: mem_busy=1 with branch_taken=1 and load_use -> all four stalls=1, all flushes=0. Drop mem_busy -> load-use stall; branch_taken ignored.
- Watchdog: MULDIV_MAX_CYCLES=8, start, never done -> hazard_err=1 after cycle 8, state IDLE, stalls released. Pulse rst -> hazard_err=0.
- Feature on: 3 stall cycles + 2 taken branches -> perf_stall_cnt=3, perf_flush_cnt=2. Feature off -> both read 0.
